// File: rtl/i2s_adc_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_adc_receiver_if
// Purpose  : Bundles the codec-side I2S ADC pins and the parallel sample
//            outputs of the I2S ADC receiver.
// Signals  : AUD_BCLK     codec bit clock (asynchronous to Clk)
//            AUD_ADCLRCK  codec frame clock, 0 = left, 1 = right
//            AUD_ADCDAT   codec serial data, MSB first
//            ADCDATA      {left, right} stereo pair, left in upper half
//            sample_valid one-Clk strobe when ADCDATA updates
//            frame_err    one-Clk strobe on a short frame
//            err_count    saturating short-frame count
// Modports : slave  - the receiver (consumes pins, produces samples)
//            master - the surrounding system (drives pins, takes samples)
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_adc_receiver_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                      AUD_BCLK;
  logic                      AUD_ADCLRCK;
  logic                      AUD_ADCDAT;
  logic [2*SAMPLE_WIDTH-1:0] ADCDATA;
  logic                      sample_valid;
  logic                      frame_err;
  logic [7:0]                err_count;

  modport slave (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output ADCDATA, sample_valid, frame_err, err_count
  );

  modport master (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  ADCDATA, sample_valid, frame_err, err_count
  );
endinterface
`default_nettype wire

// File: rtl/i2s_adc_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_adc_receiver
// Purpose  : Deserializes the codec I2S ADC stream (codec is clock master)
//            into coherent {left, right} sample pairs in the Clk domain,
//            with a one-cycle valid strobe. Capture is gated by Enable
//            (codec init complete).
// Ports    : Clk     system clock, at least 4x AUD_BCLK
//            Reset   synchronous, active-high
//            Enable  capture enable; low forces the FSM to IDLE
//            bus     i2s_adc_receiver_if.slave (pins in, samples out)
// Params   : SAMPLE_WIDTH bits per channel word (>= 2)
//            I2S_MODE     1 = I2S (MSB one BCLK after LRCK edge),
//                         0 = left-justified (MSB in the edge slot)
// Options  : ADC_FRAME_CHECK_EN - when defined, short frames drive
//            frame_err and a saturating err_count; otherwise both are 0.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter bit I2S_MODE     = 1'b1
) (
  input  wire logic          Clk,
  input  wire logic          Reset,
  input  wire logic          Enable,
  i2s_adc_receiver_if.slave  bus
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] c_full = CW'(SAMPLE_WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    DELAY = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                    r_state;

  // Pin synchronizers; the third BCLK stage provides rising-edge detection.
  logic                      r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic                      r_lrck_s1, r_lrck_s2;
  logic                      r_dat_s1,  r_dat_s2;
  logic                      r_lrck_prev;   // LRCK seen at the previous BCLK rise

  logic [SAMPLE_WIDTH-1:0]   r_shift;
  logic [SAMPLE_WIDTH-1:0]   r_left_hold;
  logic [CW-1:0]             r_bit_cnt;
  logic                      r_chan;        // channel of the word being shifted
  logic                      r_left_ok;     // a complete left word awaits its right
  logic [2*SAMPLE_WIDTH-1:0] r_adcdata;
  logic                      r_valid;

  logic                      w_bclk_rise;
  logic                      w_lrck_edge;
  logic [SAMPLE_WIDTH-1:0]   w_shift_next;
  logic [CW-1:0]             w_cnt_next;
  logic                      w_word_full;
  logic                      w_start_ch;
  logic                      w_capture;
  logic                      w_word_done;
  logic                      w_short;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_s3   <= 1'b0;
      r_lrck_s1   <= 1'b0;
      r_lrck_s2   <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
      r_lrck_prev <= 1'b0;
    end else begin
      r_bclk_s1   <= bus.AUD_BCLK;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_s3   <= r_bclk_s2;
      r_lrck_s1   <= bus.AUD_ADCLRCK;
      r_lrck_s2   <= r_lrck_s1;
      r_dat_s1    <= bus.AUD_ADCDAT;
      r_dat_s2    <= r_dat_s1;
      // LRCK history is tracked even while idle so that enabling capture
      // never manufactures a phantom frame edge.
      if (w_bclk_rise) begin
        r_lrck_prev <= r_lrck_s2;
      end
    end
  end

  assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_s3;
  assign w_lrck_edge  = w_bclk_rise & (r_lrck_s2 ^ r_lrck_prev);
  assign w_shift_next = {r_shift[SAMPLE_WIDTH-2:0], r_dat_s2};
  assign w_cnt_next   = r_bit_cnt + 1'b1;
  assign w_word_full  = (w_cnt_next == c_full);

  // A channel starts on any frame edge once aligned; alignment itself only
  // happens on a left-channel start so the first pair is always L then R.
  assign w_start_ch = w_lrck_edge &
                      (((r_state == ALIGN) & ~r_lrck_s2) |
                       (r_state == DELAY) | (r_state == SHIFT) |
                       (r_state == DONE));

  // Ordinary bit capture on a rise without a frame edge.
  assign w_capture = w_bclk_rise & ~w_lrck_edge &
                     ((r_state == DELAY) | (r_state == SHIFT));

  // In I2S the LSB of a full-slot word arrives on the same rise as the next
  // LRCK edge, so that rise both completes the word and starts the next
  // channel. In left-justified mode the edge-rise bit is the new MSB.
  assign w_word_done = Enable & w_bclk_rise & (r_state == SHIFT) &
                       w_word_full & (I2S_MODE | ~w_lrck_edge);

  assign w_short = Enable & w_lrck_edge &
                   ((r_state == DELAY) |
                    ((r_state == SHIFT) & ~(I2S_MODE & w_word_full)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_bit_cnt   <= '0;
      r_chan      <= 1'b0;
      r_left_ok   <= 1'b0;
      r_adcdata   <= '0;
      r_valid     <= 1'b0;
    end else if (!Enable) begin
      // Partial words are dropped; ADCDATA keeps the last published pair.
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_left_ok <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (r_state == IDLE) begin
        r_state <= ALIGN;
      end

      if (w_start_ch) begin
        r_chan <= r_lrck_s2;
        if (I2S_MODE) begin
          r_state   <= DELAY;
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= CW'(1);
          r_state   <= SHIFT;
        end
      end else if (w_capture) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= w_cnt_next;
        r_state   <= w_word_full ? DONE : SHIFT;
      end

      // A truncated word of either channel breaks the pair.
      if (w_short) begin
        r_left_ok <= 1'b0;
      end

      if (w_word_done) begin
        if (!r_chan) begin
          r_left_hold <= w_shift_next;
          r_left_ok   <= 1'b1;
        end else begin
          r_left_ok <= 1'b0;
          if (r_left_ok) begin
            r_adcdata <= {r_left_hold, w_shift_next};
            r_valid   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ADCDATA      = r_adcdata;
  assign bus.sample_valid = r_valid;

`ifdef ADC_FRAME_CHECK_EN
  logic       r_frame_err;
  logic [7:0] r_err_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_err <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_frame_err <= w_short;
      if (w_short && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.frame_err = r_frame_err;
  assign bus.err_count = r_err_count;
`else
  assign bus.frame_err = 1'b0;
  assign bus.err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_adc_receiver
// Purpose  : Self-checking bench for i2s_adc_receiver. Two instances share
//            the codec pins: one in I2S mode, one left-justified; only the
//            instance under test is enabled. A slot-level reference model
//            pushes expected pairs into a queue; a monitor pops and compares
//            on every sample_valid and checks ADCDATA holds in between.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_adc_receiver;

  localparam int SW = 16;
`ifdef ADC_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] en_r = 2'b00;
  logic       bclk = 1'b0, lrck = 1'b0, dat = 1'b0;
  int         cyc = 0, rise_cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  i2s_adc_receiver_if #(.SAMPLE_WIDTH(SW)) bus_i2s ();
  i2s_adc_receiver_if #(.SAMPLE_WIDTH(SW)) bus_lj ();

  assign bus_i2s.AUD_BCLK    = bclk;
  assign bus_i2s.AUD_ADCLRCK = lrck;
  assign bus_i2s.AUD_ADCDAT  = dat;
  assign bus_lj.AUD_BCLK     = bclk;
  assign bus_lj.AUD_ADCLRCK  = lrck;
  assign bus_lj.AUD_ADCDAT   = dat;

  i2s_adc_receiver #(.SAMPLE_WIDTH(SW), .I2S_MODE(1'b1)) dut_i2s (
    .Clk(Clk), .Reset(Reset), .Enable(en_r[0]), .bus(bus_i2s));
  i2s_adc_receiver #(.SAMPLE_WIDTH(SW), .I2S_MODE(1'b0)) dut_lj (
    .Clk(Clk), .Reset(Reset), .Enable(en_r[1]), .bus(bus_lj));

  typedef struct { int inst; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];

  int          checks = 0, errors = 0;
  int          mode = 0;                  // 0 = I2S instance, 1 = LJ instance
  bit          aligned [2];
  bit          left_ok [2];
  logic [SW-1:0] left_hold [2];
  int          exp_err [2];
  int          err_pulses [2];
  logic [31:0] exp_hold [2];
  bit          prev_v [2];
  logic        prev_bit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Slot-level reference: what a correct receiver makes of one channel slot.
  // change: 0 none, 1 Enable rises mid-slot, 2 Enable falls mid-slot.
  task automatic model_slot(input logic ch, input int len, input logic [SW-1:0] w,
                            input int change);
    int m = mode;
    if (!en_r[m] || change == 2) begin
      aligned[m] = 1'b0;
      left_ok[m] = 1'b0;
      return;
    end
    if (!aligned[m]) begin
      if (ch) return;
      aligned[m] = 1'b1;
    end
    if (len < SW) begin
      exp_err[m]++;
      left_ok[m] = 1'b0;
    end else if (!ch) begin
      left_hold[m] = w;
      left_ok[m]   = 1'b1;
    end else begin
      if (left_ok[m]) exp_q.push_back('{m, {left_hold[m], w}});
      left_ok[m] = 1'b0;
    end
  endtask

  // One BCLK period: codec changes pins while BCLK is low.
  task automatic bclk_cycle(input logic l, input logic d);
    @(posedge Clk); #1;
    bclk = 1'b0; lrck = l; dat = d;
    repeat (3) @(posedge Clk);
    #1;
    rise_cyc = cyc;
    bclk = 1'b1;
    repeat (3) @(posedge Clk);
  endtask

  task automatic send_slot(input logic ch, input int len, input logic [SW-1:0] w,
                           input int change);
    logic [SW-1:0] sh;
    logic b, o;
    model_slot(ch, len, w, change);
    for (int k = 0; k < len; k++) begin
      sh = w << k;
      b  = sh[SW-1];
      if (mode == 0) begin
        o = prev_bit;          // I2S: data lags the frame clock by one BCLK
        prev_bit = b;
      end else begin
        o = b;
      end
      if (change != 0 && k == len / 2) en_r[mode] = (change == 1);
      bclk_cycle(ch, o);
    end
  endtask

  task automatic send_pair(input logic [SW-1:0] l, input logic [SW-1:0] r,
                           input int ll, input int lr);
    send_slot(1'b0, ll, l, 0);
    send_slot(1'b1, lr, r, 0);
  endtask

  function automatic int rnd_len();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(4, 15));
    case ($urandom_range(0, 3))
      0: return 16;
      1: return 18;
      2: return 24;
      default: return 32;
    endcase
  endfunction

  task automatic mon(input int i, input logic v, input logic [31:0] d, input logic fe);
    exp_t e;
    if (Reset) begin
      exp_hold[i] = 32'd0;
      prev_v[i]   = 1'b0;
      return;
    end
    if (fe) err_pulses[i]++;
    if (v) begin
      chk("valid_pulse_width", {31'd0, prev_v[i]}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid inst %0d actual %h required no pulse", i, d);
      end else begin
        e = exp_q.pop_front();
        chk("pair_instance", i, e.inst);
        chk("pair_data", d, e.data);
        chk("valid_latency", cyc - rise_cyc, 3);
        exp_hold[i] = e.data;
      end
    end else begin
      chk("adcdata_hold", d, exp_hold[i]);
    end
    prev_v[i] = v;
  endtask

  always @(negedge Clk) begin
    mon(0, bus_i2s.sample_valid, bus_i2s.ADCDATA, bus_i2s.frame_err);
    mon(1, bus_lj.sample_valid, bus_lj.ADCDATA, bus_lj.frame_err);
  end

  task automatic phase_end(input int i, input logic [7:0] ec);
    int e = FC ? exp_err[i] : 0;
    chk("pending_pairs", exp_q.size(), 0);
    chk("err_count", ec, (e > 255) ? 255 : e);
    chk("frame_err_pulses", err_pulses[i], e);
  endtask

  initial begin
    logic [SW-1:0] lw, rw;
    for (int i = 0; i < 2; i++) begin
      aligned[i] = 0; left_ok[i] = 0; left_hold[i] = '0;
      exp_err[i] = 0; err_pulses[i] = 0; exp_hold[i] = '0; prev_v[i] = 0;
    end
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("reset_adcdata_i2s", bus_i2s.ADCDATA, 32'd0);
    chk("reset_valid_i2s", {31'd0, bus_i2s.sample_valid}, 32'd0);
    chk("reset_frame_err_i2s", {31'd0, bus_i2s.frame_err}, 32'd0);
    chk("reset_err_count_i2s", {24'd0, bus_i2s.err_count}, 32'd0);
    chk("reset_adcdata_lj", bus_lj.ADCDATA, 32'd0);
    chk("reset_err_count_lj", {24'd0, bus_lj.err_count}, 32'd0);

    // ---------------- I2S instance ----------------
    mode = 0;
    en_r[0] = 1'b1;
    send_slot(1'b1, 16, 16'h0000, 0);                  // right preamble, skipped
    send_pair(16'h1234, 16'hABCD, 16, 16);
    send_slot(1'b0, 16, 16'h5A5A, 2);                  // Enable drops mid-left
    send_slot(1'b1, 16, 16'hA5A5, 1);                  // Enable rises mid-right
    send_pair(16'h0001, 16'h8000, 16, 16);
    send_slot(1'b0, 10, 16'hFFC0, 0);                  // truncated left
    send_slot(1'b1, 16, 16'h5555, 0);                  // orphan right
    send_pair(16'hAAAA, 16'h0F0F, 16, 16);
    send_pair(16'hFFFF, 16'hFFFF, 24, 24);             // padded slots
    send_slot(1'b0, 16, 16'h1111, 2);
    send_slot(1'b1, 16, 16'h2222, 1);
    send_pair(16'h7FFF, 16'h8001, 16, 16);
    repeat (24) begin
      lw = SW'($urandom);
      rw = SW'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        send_slot(1'b0, rnd_len(), lw, 2);
        send_slot(1'b1, rnd_len(), rw, 1);
      end else begin
        send_pair(lw, rw, rnd_len(), rnd_len());
      end
    end
    send_slot(1'b0, 16, 16'h0000, 0);                  // flushes the last I2S LSB
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    phase_end(0, bus_i2s.err_count);

    // ---------------- left-justified instance ----------------
    en_r[0] = 1'b0;
    mode = 1;
    en_r[1] = 1'b1;
    send_slot(1'b1, 16, 16'h0000, 0);
    send_pair(16'hC3C3, 16'h3C3C, 16, 16);
    repeat (12) begin
      lw = SW'($urandom);
      rw = SW'($urandom);
      send_pair(lw, rw, rnd_len(), rnd_len());
    end
    send_slot(1'b0, 16, 16'h0000, 0);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    phase_end(1, bus_lj.err_count);

    // ---------------- reset in the middle of a word ----------------
    for (int k = 0; k < 5; k++) bclk_cycle(1'b1, k[0]);
    for (int k = 0; k < 5; k++) bclk_cycle(1'b0, 1'b1);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    chk("midword_reset_adcdata_lj", bus_lj.ADCDATA, 32'd0);
    chk("midword_reset_err_count_lj", {24'd0, bus_lj.err_count}, 32'd0);
    chk("midword_reset_adcdata_i2s", bus_i2s.ADCDATA, 32'd0);
    repeat (20) @(posedge Clk);
    @(negedge Clk);
    chk("pending_after_reset", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Deserializes the codec's I2S ADC stream (AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, codec as clock master) into parallel left/right samples in the Clk domain. It is the capture-side counterpart of the DAC serializer inside the audio interface and feeds the pedal-board input path. It presents coherent stereo pairs with a one-cycle valid strobe. Capture is gated by the codec-init-complete handshake.

## Interface
- SAMPLE_WIDTH, 16: bits per channel word.
- I2S_MODE, 1: 1 = I2S (one-BCLK delay after LRCK edge); 0 = left-justified (MSB in first slot).
- Clk  in  1  system clock; must be ≥ 4× AUD_BCLK frequency.
- Reset  in  1  synchronous, active-high.
- Enable  in  1  capture enable, driven from codec INIT_FINISH; low forces IDLE.
- AUD_BCLK  in  1  codec bit clock, asynchronous.
- AUD_ADCLRCK  in  1  codec frame clock, asynchronous; 0 = left, 1 = right.
- AUD_ADCDAT  in  1  codec serial data, asynchronous, MSB first.
- ADCDATA  out  2*SAMPLE_WIDTH  {left, right}; left in upper half.
- sample_valid  out  1  one-Clk pulse when ADCDATA updates.
- frame_err  out  1  one-Clk pulse on short frame (ADC_FRAME_CHECK_EN only; else tied 0).
- err_count  out  8  saturating short-frame count (ADC_FRAME_CHECK_EN only; else tied 0).

## Operation
- All three pins pass through 2-flop synchronizers; a third BCLK flop gives bclk_rise = sync high and previous low. All decisions occur only on bclk_rise cycles, using synchronized LRCK/DAT of that cycle.
- lrck_edge = synchronized LRCK at this bclk_rise differs from value at previous bclk_rise.
- FSM states: IDLE, ALIGN, DELAY, SHIFT, DONE.
  - IDLE: Enable low or after Reset. Enable high -> ALIGN.
  - ALIGN: wait for lrck_edge with LRCK = 0 (left start); then DELAY if I2S_MODE, else capture MSB this rise and go SHIFT.
  - DELAY: next bclk_rise captures MSB -> SHIFT.
  - SHIFT: shift DAT into channel shift register MSB-first; bit counter increments; after SAMPLE_WIDTH bits -> DONE.
  - DONE: ignore further bits; on lrck_edge go DELAY (I2S) or capture MSB (LJ) for the new channel.
- Left word completion copies shift register to left holding register. Right word completion loads ADCDATA = {left_hold, right} and pulses sample_valid next cycle. Left is never published alone; pairs are always coherent.
- Short frame: lrck_edge while in DELAY/SHIFT before SAMPLE_WIDTH bits collected -> partial word discarded, counter cleared, new channel starts normally. If the discarded word was left, the following right word is also not published (no valid for that frame).
- Enable falling mid-word: return to IDLE next cycle, partial data discarded, ADCDATA holds last value.

## Timing
- Reset values: ADCDATA = 0, sample_valid = 0, frame_err = 0, err_count = 0, FSM = IDLE, counters 0.
- bclk_rise asserts 2 Clk after a pin BCLK rise (synchronizer latency); bit capture on that cycle.
- sample_valid and ADCDATA update 1 Clk after the bclk_rise capturing the right LSB; sample_valid high exactly 1 Clk.
- First valid pair requires a full left then right frame after alignment; frames in progress at Enable rise are skipped.
- frame_err pulses 1 Clk after the offending lrck_edge; err_count saturates at 255.
- Reset mid-word takes priority over all events that cycle.

## Configuration
- ADC_FRAME_CHECK_EN defined: short-frame detection drives frame_err and err_count as above.
- Undefined: frame_err and err_count constant 0, counter logic removed; short-frame discard behaviour unchanged.

## Test plan
- Reset, Enable=1, BFM sends I2S frame left 16'h1234, right 16'hABCD -> one sample_valid pulse, ADCDATA = 32'h1234ABCD, 3 Clk after right LSB pin edge.
- Enable=1 asserted mid-right-channel, then frames L=16'h0001/R=16'h8000 -> first pulse shows 32'h00018000, partial frame never published.
- Left frame truncated to 10 bits, then full right 16'h5555, then full pair 16'hAAAA/16'h0F0F -> no valid for first frame, frame_err one pulse, err_count=1, next ADCDATA = 32'hAAAA0F0F.
- 24-bit slots per channel carrying 16'hFFFF + 8 extra zero bits -> ADCDATA = 32'hFFFFFFFF; extra bits ignored.
- Enable dropped mid-left word, re-raised, pair 16'h7FFF/16'h8001 sent -> ADCDATA holds old value until pulse with 32'h7FFF8001.
- I2S_MODE=0, left-justified pair 16'hC3C3/16'h3C3C -> ADCDATA = 32'hC3C33C3C.
